// File: rtl/cfg_bank_writer_if.sv
// Bitstream word stream between the loader and the configuration bank writer.
//   din        : bitstream word, din[0] maps to the lowest bl index of its slice
//   din_valid  : din holds a valid word
//   din_ready  : writer accepts din this cycle
// master = loader side, slave = writer side.
interface cfg_bank_writer_if #(
  parameter int unsigned DIN_WIDTH = 8
) ();
  logic [DIN_WIDTH-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/cfg_bank_writer.sv
// Memory-bank configuration writer. Assembles one bit-line column per row from a
// valid/ready word stream, drives it onto bl, strobes the one-hot word line of
// that row for WL_PULSE cycles, and repeats for all WL_WIDTH rows.
//   i_clk     : clock, rising edge
//   i_reset   : synchronous, active-low reset
//   i_start   : launch a pass (sampled only in idle/done)
//   i_abort   : cancel the pass, back to idle (priority over all but reset)
//   i_stream  : bitstream word stream (slave side)
//   o_bl      : bit-line data
//   o_wl      : one-hot word-line strobe
//   o_row     : row currently loading or writing
//   o_busy    : pass in progress
//   o_done    : pass completed, held until next start
module cfg_bank_writer #(
  parameter int unsigned BL_WIDTH  = 32,
  parameter int unsigned WL_WIDTH  = 40,
  parameter int unsigned DIN_WIDTH = 8,
  parameter int unsigned WL_PULSE  = 2,
  localparam int unsigned RowW     = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  cfg_bank_writer_if.slave        i_stream,
  output logic [0:BL_WIDTH-1]     o_bl,
  output logic [0:WL_WIDTH-1]     o_wl,
  output logic [RowW-1:0]         o_row,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned Beats  = BL_WIDTH / DIN_WIDTH;
  localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned PulseW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StWrite, StHold, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [BeatW-1:0]     r_beat, w_beat_d;
  logic [PulseW-1:0]    r_pulse, w_pulse_d;
  logic [RowW-1:0]      r_row, w_row_d;
  logic [0:BL_WIDTH-1]  r_bl, w_bl_d;
  logic [0:WL_WIDTH-1]  r_wl, w_wl_d;
  logic                 r_busy, w_busy_d;
  logic                 r_done, w_done_d;
  logic                 w_din_ready;
  logic                 w_xfer;
  logic [0:DIN_WIDTH-1] w_din_asc;

  assign w_xfer = w_din_ready & i_stream.din_valid;

  // Re-order din so din[0] lands on the lowest bl index of the slice.
  always_comb begin
    w_din_asc = '0;
    for (int i = 0; i < DIN_WIDTH; i++) begin
      w_din_asc[i] = i_stream.din[i];
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_beat_d  = r_beat;
    w_pulse_d = r_pulse;
    w_bl_d    = r_bl;

    if (w_xfer) begin
      for (int k = 0; k < Beats; k++) begin
        if (r_beat == BeatW'(k)) begin
          w_bl_d[k*DIN_WIDTH +: DIN_WIDTH] = w_din_asc;
        end
      end
    end

    case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d = StLoad;
          w_row_d   = '0;
          w_beat_d  = '0;
        end
      end
      StLoad: begin
        if (w_xfer) begin
          w_beat_d = r_beat + 1'b1;
          if (r_beat == BeatW'(Beats - 1)) w_state_d = StSetup;
        end
      end
      StSetup: begin
        w_state_d = StWrite;
        w_pulse_d = '0;
      end
      StWrite: begin
        if (r_pulse == PulseW'(WL_PULSE - 1)) begin
          w_state_d = StHold;
        end else begin
          w_pulse_d = r_pulse + 1'b1;
        end
      end
      StHold: begin
        if (r_row == RowW'(WL_WIDTH - 1)) begin
          w_state_d = StDone;
        end else begin
          w_state_d = StLoad;
          w_row_d   = r_row + 1'b1;
          w_beat_d  = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Abort also covers start+abort in idle/done; bl is deliberately kept.
    if (i_abort) begin
      w_state_d = StIdle;
      w_row_d   = '0;
      w_beat_d  = '0;
    end
  end

  // Outputs: registered ones are decoded from the next state so they line up
  // with the state they belong to; din_ready is the only combinational output.
  always_comb begin
    w_din_ready = (r_state == StLoad) && !i_abort;
    w_wl_d      = '0;
    if (w_state_d == StWrite) w_wl_d[w_row_d] = 1'b1;
    w_busy_d    = (w_state_d == StLoad) || (w_state_d == StSetup) ||
                  (w_state_d == StWrite) || (w_state_d == StHold);
    w_done_d    = (w_state_d == StDone);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_beat  <= '0;
      r_pulse <= '0;
      r_row   <= '0;
      r_bl    <= '0;
      r_wl    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_beat  <= w_beat_d;
      r_pulse <= w_pulse_d;
      r_row   <= w_row_d;
      r_bl    <= w_bl_d;
      r_wl    <= w_wl_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign i_stream.din_ready = w_din_ready;
  assign o_bl   = r_bl;
  assign o_wl   = r_wl;
  assign o_row  = r_row;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_cfg_bank_writer.sv
// Self-checking bench for cfg_bank_writer (BL=32, DIN=8, WL=4, WL_PULSE=2).
// Expected strobes are queued as each row is driven and popped on each wl rise.
module tb_cfg_bank_writer;
  localparam int unsigned BL      = 32;
  localparam int unsigned WL      = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned WP      = 2;
  localparam int unsigned RW      = 2;
  localparam int unsigned BEATS   = BL / DW;
  localparam int unsigned ROW_CYC = BEATS + WP + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [0:BL-1] bl;
  logic [0:WL-1] wl;
  logic [RW-1:0] row;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  cfg_bank_writer_if #(.DIN_WIDTH(DW)) u_if ();

  cfg_bank_writer #(
    .BL_WIDTH (BL),
    .WL_WIDTH (WL),
    .DIN_WIDTH(DW),
    .WL_PULSE (WP)
  ) u_dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_abort (abort),
    .i_stream(u_if),
    .o_bl    (bl),
    .o_wl    (wl),
    .o_row   (row),
    .o_busy  (busy),
    .o_done  (done)
  );

  typedef struct {
    int            row;
    logic [0:BL-1] bl;
  } strobe_t;

  strobe_t       sb_q[$];
  int            rise_q[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            t_load = 0;
  int            xfer_cyc = 0;
  int            done_cyc = 0;
  int            row_xfer[WL];
  bit            mon_en = 1'b0;
  bit            skip_inv = 1'b0;
  logic [0:WL-1] prev_wl = '0;
  logic [0:BL-1] prev_bl = '0;
  logic          prev_done = 1'b0;
  int            pulse_len = 0;
  strobe_t       mon_e;
  logic [0:WL-1] exp_wl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:BL-1] pack_row(input int first);
    logic [0:BL-1] v;
    logic [7:0]    w;
    v = '0;
    for (int k = 0; k < BEATS; k++) begin
      w = 8'(first + k);
      for (int i = 0; i < DW; i++) v[k*DW+i] = w[i];
    end
    return v;
  endfunction

  // Per-cycle monitor: one-hot, strobe scoreboard, pulse length, bl stability.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("wl_onehot", 64'($countones(wl) <= 1), 64'(1));
      if (wl != '0 && prev_wl == '0) begin
        rise_q.push_back(cyc);
        pulse_len = 1;
        if (sb_q.size() == 0) begin
          check_eq("strobe_unexpected", 64'(wl), 64'(0));
        end else begin
          mon_e  = sb_q.pop_front();
          exp_wl = '0;
          exp_wl[RW'(mon_e.row)] = 1'b1;
          check_eq("strobe_wl", 64'(wl), 64'(exp_wl));
          check_eq("strobe_bl", 64'(bl), 64'(mon_e.bl));
        end
        if (!skip_inv) check_eq("bl_before_strobe", 64'(bl), 64'(prev_bl));
      end else if (wl != '0) begin
        pulse_len++;
      end
      if (prev_wl != '0 && !skip_inv) check_eq("bl_stable", 64'(bl), 64'(prev_bl));
      if (wl == '0 && prev_wl != '0 && !skip_inv)
        check_eq("wl_pulse_len", 64'(pulse_len), 64'(WP));
      if (done && !prev_done) done_cyc = cyc;
    end
    prev_wl   = wl;
    prev_bl   = bl;
    prev_done = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    rise_q.delete();
    start  = 1'b1;
    t_load = cyc + 1;
    step();
    start  = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit gap);
    bit got = 1'b0;
    u_if.din       = d;
    u_if.din_valid = 1'b1;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (u_if.din_ready) begin
        got      = 1'b1;
        xfer_cyc = cyc;
      end
      step();
    end
    if (!got) check_eq("beat_timeout", 64'(0), 64'(1));
    if (gap) begin
      u_if.din_valid = 1'b0;
      step();
    end
  endtask

  task automatic send_row(input int r, input int first, input bit gap, input bit poke);
    sb_q.push_back('{row: r, bl: pack_row(first)});
    for (int k = 0; k < BEATS; k++) begin
      if (poke && k == 2) begin
        u_if.din_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check_eq("start_ignored_row", 64'(row), 64'(r));
        check_eq("start_ignored_busy", 64'(busy), 64'(1));
        step();
      end
      send_beat(8'(first + k), gap);
    end
    u_if.din_valid = 1'b0;
    row_xfer[r] = xfer_cyc;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      got = done;
      step();
    end
    if (!got) check_eq("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_wl(input int r);
    bit got = 1'b0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (wl[RW'(r)]) got = 1'b1;
      else step();
    end
    if (!got) check_eq("wl_timeout", 64'(0), 64'(1));
  endtask

  task automatic full_pass(input int base, input bit gap1, input bit poke, input bit timed);
    start_pass();
    for (int r = 0; r < WL; r++) send_row(r, base + r * BEATS, gap1 && r == 1, poke && r == 0);
    wait_done();
    check_eq("pass_rises", 64'(rise_q.size()), 64'(WL));
    for (int r = 0; r < WL; r++)
      if (r < rise_q.size()) check_eq("strobe_delay", 64'(rise_q[r] - row_xfer[r]), 64'(2));
    if (timed) check_eq("done_latency", 64'(done_cyc - t_load), 64'(WL * ROW_CYC));
    @(negedge clk);
    check_eq("done_row", 64'(row), 64'(WL - 1));
    check_eq("done_busy", 64'(busy), 64'(0));
    check_eq("sb_empty", 64'(sb_q.size()), 64'(0));
    step();
  endtask

  initial begin
    u_if.din       = '0;
    u_if.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    check_eq("rst_wl", 64'(wl), 64'(0));
    check_eq("rst_bl", 64'(bl), 64'(0));
    check_eq("rst_row", 64'(row), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_ready", 64'(u_if.din_ready), 64'(0));
    step();
    reset  = 1'b1;
    mon_en = 1'b1;
    step();

    // Nominal pass, words 0x01..0x10, continuous input.
    full_pass(32'h01, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    check_eq("done_held", 64'(done), 64'(1));
    check_eq("done_wl", 64'(wl), 64'(0));
    step();

    // Gapped row 1 plus a start pulse during LOAD, launched from DONE.
    full_pass(32'h21, 1'b1, 1'b1, 1'b0);

    // start and abort together in DONE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_eq("sa_done", 64'(done), 64'(0));
    check_eq("sa_busy", 64'(busy), 64'(0));
    check_eq("sa_row", 64'(row), 64'(0));
    step();
    @(negedge clk);
    check_eq("sa_idle_busy", 64'(busy), 64'(0));
    check_eq("sa_idle_ready", 64'(u_if.din_ready), 64'(0));
    step();

    // Abort during WRITE of row 1.
    start_pass();
    send_row(0, 32'h80, 1'b0, 1'b0);
    send_row(1, 32'h84, 1'b0, 1'b0);
    wait_wl(1);
    skip_inv = 1'b1;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    @(negedge clk);
    check_eq("abort_wl", 64'(wl), 64'(0));
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_row", 64'(row), 64'(0));
    check_eq("abort_ready", 64'(u_if.din_ready), 64'(0));
    check_eq("abort_bl_kept", 64'(bl), 64'(pack_row(32'h84)));
    step();
    skip_inv = 1'b0;

    // Abort in LOAD blocks the offered beat.
    start_pass();
    u_if.din       = 8'hAA;
    u_if.din_valid = 1'b1;
    abort          = 1'b1;
    @(negedge clk);
    check_eq("abort_blocks_ready", 64'(u_if.din_ready), 64'(0));
    step();
    abort          = 1'b0;
    u_if.din_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_load_busy", 64'(busy), 64'(0));
    check_eq("abort_load_bl", 64'(bl), 64'(pack_row(32'h84)));
    step();

    // Fresh start reloads from row 0.
    full_pass(32'h41, 1'b0, 1'b0, 1'b1);

    // Reset during WRITE of row 2.
    start_pass();
    for (int r = 0; r < 3; r++) send_row(r, 32'hA1 + r * BEATS, 1'b0, 1'b0);
    wait_wl(2);
    skip_inv = 1'b1;
    reset    = 1'b0;
    step();
    @(negedge clk);
    check_eq("mid_rst_wl", 64'(wl), 64'(0));
    check_eq("mid_rst_bl", 64'(bl), 64'(0));
    check_eq("mid_rst_busy", 64'(busy), 64'(0));
    check_eq("mid_rst_row", 64'(row), 64'(0));
    check_eq("mid_rst_ready", 64'(u_if.din_ready), 64'(0));
    step();
    reset    = 1'b1;
    skip_inv = 1'b0;
    step();

    // Normal pass after reset release, then a second identical wl sequence.
    full_pass(32'h61, 1'b0, 1'b0, 1'b1);
    full_pass(32'hC1, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
